// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the core's dmem port: clears the array after reset,
// then serves single-cycle loads/stores with range checking and saturating access counters.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_enable,
  input  logic                  store_enable,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [DATA_WIDTH-1:0] dmem_dataIn,
  output logic [DATA_WIDTH-1:0] dmem_dataOut,
  output logic                  ready,
  output logic                  addr_error,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef enum logic {StClear, StReady} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    addr_error_q, addr_error_d;
  logic [CNT_WIDTH-1:0]    rd_count_q, rd_count_d;
  logic [CNT_WIDTH-1:0]    wr_count_q, wr_count_d;

  logic [DATA_WIDTH-1:0]   mem [Depth];
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_widx;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;

  assign in_range = (dmem_address[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
  assign idx      = dmem_address[DEPTH_LOG2-1:0];

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    data_out_d   = data_out_q;
    addr_error_d = 1'b0;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    mem_we       = 1'b0;
    mem_widx     = clear_ptr_q;
    mem_wdata    = '0;

    unique case (state_q)
      StClear: begin
        // Requests are ignored entirely while the array is being zeroed.
        mem_we      = 1'b1;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == '1) state_d = StReady;
      end
      StReady: begin
        if (mem_enable) begin
          if (!in_range) begin
            data_out_d   = '0;
            addr_error_d = 1'b1;
          end else if (store_enable) begin
            mem_we    = 1'b1;
            mem_widx  = idx;
            mem_wdata = dmem_dataIn;
            if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
          end else begin
            data_out_d = mem[idx];
            if (rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StClear;
      clear_ptr_q  <= '0;
      data_out_q   <= '0;
      addr_error_q <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      data_out_q   <= data_out_d;
      addr_error_q <= addr_error_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Array has no reset; its contents are defined by the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign dmem_dataOut = data_out_q;
  assign ready        = (state_q == StReady);
  assign addr_error   = addr_error_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default instance plus a small-counter instance for saturation.
module tb_dmem_responder;

  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned SCW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_enable = 1'b0;
  logic          store_enable = 1'b0;
  logic [AW-1:0] dmem_address = '0;
  logic [DW-1:0] dmem_dataIn = '0;

  logic [DW-1:0] dmem_dataOut;
  logic          ready, addr_error;
  logic [CW-1:0] rd_count, wr_count;

  logic [DW-1:0]  s_dataOut;
  logic           s_ready, s_addr_error;
  logic [SCW-1:0] s_rd_count, s_wr_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .mem_enable   (mem_enable),
    .store_enable (store_enable),
    .dmem_address (dmem_address),
    .dmem_dataIn  (dmem_dataIn),
    .dmem_dataOut (dmem_dataOut),
    .ready        (ready),
    .addr_error   (addr_error),
    .rd_count     (rd_count),
    .wr_count     (wr_count)
  );

  dmem_responder #(
    .DEPTH_LOG2 (4),
    .CNT_WIDTH  (SCW)
  ) dut_s (
    .clk          (clk),
    .rst          (rst),
    .mem_enable   (mem_enable),
    .store_enable (store_enable),
    .dmem_address (dmem_address),
    .dmem_dataIn  (dmem_dataIn),
    .dmem_dataOut (s_dataOut),
    .ready        (s_ready),
    .addr_error   (s_addr_error),
    .rd_count     (s_rd_count),
    .wr_count     (s_wr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic en, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    mem_enable   = en;
    store_enable = we;
    dmem_address = a;
    dmem_dataIn  = d;
    tick();
    mem_enable   = 1'b0;
    store_enable = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests_run++;
    if (dmem_dataOut !== '0) begin
      tests_failed++; $display("FAIL reset_dout: got %h want 0", dmem_dataOut);
    end
    tests_run++;
    if ({ready, addr_error} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 00", {ready, addr_error});
    end
    tests_run++;
    if (rd_count !== '0 || wr_count !== '0) begin
      tests_failed++; $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rd_count, wr_count);
    end
  endtask

  task automatic test_clear();
    int   n = 0;
    int   s_n = -1;
    logic bad = 1'b0;
    rst = 1'b1;
    while (!ready && n < 400) begin
      mem_enable = 1'b0; store_enable = 1'b0;
      if (n == 9) begin
        mem_enable = 1'b1; store_enable = 1'b1; dmem_address = 7; dmem_dataIn = 64'hAB;
      end
      if (n == 19) begin
        mem_enable = 1'b1; store_enable = 1'b1; dmem_address = 32'h100; dmem_dataIn = 64'h1;
      end
      if (n == 29) begin
        mem_enable = 1'b1; store_enable = 1'b0; dmem_address = 7;
      end
      tick();
      n++;
      if (s_ready && s_n < 0) s_n = n;
      if (!ready && (dmem_dataOut !== '0 || addr_error !== 1'b0 || rd_count !== '0 ||
                     wr_count !== '0)) bad = 1'b1;
    end
    mem_enable = 1'b0; store_enable = 1'b0;
    tests_run++;
    if (n != 256) begin
      tests_failed++; $display("FAIL clear_len: ready after %0d cycles want 256", n);
    end
    tests_run++;
    if (s_n != 16) begin
      tests_failed++; $display("FAIL clear_len_small: ready after %0d cycles want 16", s_n);
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++; $display("FAIL clear_ignore: got activity=%b want 0", bad);
    end
    tests_run++;
    if (rd_count !== '0 || wr_count !== '0) begin
      tests_failed++; $display("FAIL clear_counts: got rd=%0d wr=%0d want 0/0", rd_count, wr_count);
    end
  endtask

  task automatic test_post_clear();
    req(1'b1, 1'b0, 5, '0);
    tests_run++;
    if (dmem_dataOut !== 64'h0 || rd_count !== 16'd1) begin
      tests_failed++; $display("FAIL read5: got %h rd=%0d want 0 rd=1", dmem_dataOut, rd_count);
    end
    req(1'b1, 1'b0, 7, '0);
    tests_run++;
    if (dmem_dataOut !== 64'h0 || rd_count !== 16'd2) begin
      tests_failed++; $display("FAIL read7: got %h rd=%0d want 0 rd=2", dmem_dataOut, rd_count);
    end
  endtask

  task automatic test_write_read();
    req(1'b1, 1'b1, 3, 64'hDEADBEEFCAFEF00D);
    tests_run++;
    if (dmem_dataOut !== 64'h0 || wr_count !== 16'd1) begin
      tests_failed++; $display("FAIL wr3: got %h wr=%0d want 0 wr=1", dmem_dataOut, wr_count);
    end
    req(1'b1, 1'b0, 3, '0);
    tests_run++;
    if (dmem_dataOut !== 64'hDEADBEEFCAFEF00D || rd_count !== 16'd3 || wr_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL rd3: got %h rd=%0d wr=%0d want deadbeefcafef00d rd=3 wr=1",
               dmem_dataOut, rd_count, wr_count);
    end
    req(1'b1, 1'b1, 4, 64'h1234);
    tests_run++;
    if (dmem_dataOut !== 64'hDEADBEEFCAFEF00D || wr_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL wr_hold: got %h wr=%0d want deadbeefcafef00d wr=2", dmem_dataOut, wr_count);
    end
  endtask

  task automatic test_out_of_range();
    req(1'b1, 1'b1, 32'h100, 64'h1111);
    tests_run++;
    if (addr_error !== 1'b1 || dmem_dataOut !== 64'h0 || wr_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL oor_wr: got err=%b dout=%h wr=%0d want 1 0 2", addr_error, dmem_dataOut,
               wr_count);
    end
    tick();
    tests_run++;
    if (addr_error !== 1'b0) begin
      tests_failed++; $display("FAIL oor_pulse: got err=%b want 0", addr_error);
    end
    req(1'b1, 1'b0, 0, '0);
    tests_run++;
    if (dmem_dataOut !== 64'h0 || rd_count !== 16'd4) begin
      tests_failed++; $display("FAIL rd0: got %h rd=%0d want 0 rd=4", dmem_dataOut, rd_count);
    end
    req(1'b1, 1'b0, 3, '0);
    req(1'b1, 1'b0, 32'h8000_0003, '0);
    tests_run++;
    if (addr_error !== 1'b1 || dmem_dataOut !== 64'h0 || rd_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL oor_rd: got err=%b dout=%h rd=%0d want 1 0 5", addr_error, dmem_dataOut,
               rd_count);
    end
    req(1'b1, 1'b0, 3, '0);
    tests_run++;
    if (addr_error !== 1'b0 || dmem_dataOut !== 64'hDEADBEEFCAFEF00D || rd_count !== 16'd6) begin
      tests_failed++;
      $display("FAIL oor_recover: got err=%b dout=%h rd=%0d want 0 deadbeefcafef00d 6",
               addr_error, dmem_dataOut, rd_count);
    end
  endtask

  task automatic test_back_to_back();
    req(1'b1, 1'b1, 10, 64'h0123_4567_89AB_CDEF);
    req(1'b1, 1'b1, 11, 64'hFEDC_BA98_7654_3210);
    req(1'b1, 1'b0, 10, '0);
    tests_run++;
    if (dmem_dataOut !== 64'h0123_4567_89AB_CDEF) begin
      tests_failed++; $display("FAIL b2b_rd10: got %h want 0123456789abcdef", dmem_dataOut);
    end
    req(1'b1, 1'b0, 11, '0);
    tests_run++;
    if (dmem_dataOut !== 64'hFEDC_BA98_7654_3210) begin
      tests_failed++; $display("FAIL b2b_rd11: got %h want fedcba9876543210", dmem_dataOut);
    end
    req(1'b0, 1'b1, 10, 64'h5A5A);
    tests_run++;
    if (dmem_dataOut !== 64'hFEDC_BA98_7654_3210 || wr_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL idle_hold: got %h wr=%0d want fedcba9876543210 wr=4", dmem_dataOut, wr_count);
    end
    req(1'b1, 1'b0, 10, '0);
    tests_run++;
    if (dmem_dataOut !== 64'h0123_4567_89AB_CDEF || rd_count !== 16'd9) begin
      tests_failed++;
      $display("FAIL idle_nowrite: got %h rd=%0d want 0123456789abcdef rd=9", dmem_dataOut,
               rd_count);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    req(1'b1, 1'b1, 9, 64'h55);
    req(1'b1, 1'b0, 9, '0);
    tests_run++;
    if (dmem_dataOut !== 64'h55) begin
      tests_failed++; $display("FAIL pre_reset_rd9: got %h want 55", dmem_dataOut);
    end
    mem_enable = 1'b1; dmem_address = 9;
    rst = 1'b0;
    #1;
    tests_run++;
    if (dmem_dataOut !== '0 || ready !== 1'b0 || rd_count !== '0 || wr_count !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got dout=%h rdy=%b rd=%0d wr=%0d want all 0", dmem_dataOut,
               ready, rd_count, wr_count);
    end
    mem_enable = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    wait_ready(cyc);
    tests_run++;
    if (cyc != 256) begin
      tests_failed++; $display("FAIL reclear_len: ready after %0d cycles want 256", cyc);
    end
    req(1'b1, 1'b0, 9, '0);
    tests_run++;
    if (dmem_dataOut !== 64'h0 || rd_count !== 16'd1 || wr_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL post_reset_rd9: got %h rd=%0d wr=%0d want 0 1 0", dmem_dataOut, rd_count,
               wr_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      req(1'b1, 1'b0, 0, '0);
      if (i == 12) begin
        tests_run++;
        if (s_rd_count !== 4'd14) begin
          tests_failed++; $display("FAIL sat_mid: got %0d want 14", s_rd_count);
        end
      end
    end
    tests_run++;
    if (s_rd_count !== 4'hF || s_wr_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL sat_end: got rd=%0d wr=%0d want 15 0", s_rd_count, s_wr_count);
    end
    tests_run++;
    if (rd_count !== 16'd21) begin
      tests_failed++; $display("FAIL wide_count: got %0d want 21", rd_count);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_post_clear();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
